instruction_loader: RTL and testbench

- Upstream feeder of the IF-stage instruction memory.
- Receives program bytes from the debug UART receiver and assembles them into 32-bit little-endian words.
- Drives the memory's clear/write/instruction inputs, one word per write pulse.
- Stops on a HALT word, on a full memory, or on error; reports status to the debug unit.

---
 rtl/instruction_loader_pkg.sv | 22 ++
 rtl/instruction_loader_if.sv | 27 ++
 rtl/instruction_loader_byte_assembler.sv | 49 ++++
 rtl/instruction_loader.sv | 119 +++++++++++
 tb/tb_instruction_loader.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared constants and state encoding for the instruction loader
// and its byte assembler.
package instruction_loader_pkg;

  localparam int                LOADER_WORD_WIDTH = 32;
  localparam int                LOADER_BYTE_SIZE  = 8;
  localparam logic [31:0]       LOADER_HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RECV  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  function automatic logic is_busy(input state_e state);
    return (state == ST_CLEAR) || (state == ST_RECV) || (state == ST_WRITE);
  endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// UART byte stream in, instruction-memory control out. The loader
// is the master; the UART/memory side is the slave.
interface instruction_loader_if
  import instruction_loader_pkg::*;
#(
  parameter int WORD_WIDTH_BITS = LOADER_WORD_WIDTH,
  parameter int BYTE_SIZE       = LOADER_BYTE_SIZE
);

  logic [BYTE_SIZE-1:0]       i_rx_data;
  logic                       i_rx_valid;
  logic                       i_mem_full;
  logic                       o_clear;
  logic                       o_inst_write;
  logic [WORD_WIDTH_BITS-1:0] o_instruction;

  modport master (
    input  i_rx_data, i_rx_valid, i_mem_full,
    output o_clear, o_inst_write, o_instruction
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_mem_full,
    input  o_clear, o_inst_write, o_instruction
  );

endinterface

// File: rtl/instruction_loader_byte_assembler.sv
// Packs UART bytes little-endian into a word; lane 0 lands in the
// low byte. Lanes are overwritten in place rather than cleared per word.
module instruction_loader_byte_assembler
  import instruction_loader_pkg::*;
#(
  parameter int WORD_WIDTH_BITS = LOADER_WORD_WIDTH,
  parameter int BYTE_SIZE       = LOADER_BYTE_SIZE
)(
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_clear,
  input  logic                       i_capture,
  input  logic [BYTE_SIZE-1:0]       i_byte,
  output logic [WORD_WIDTH_BITS-1:0] o_word,
  output logic                       o_word_ready
);

  localparam int LANES      = WORD_WIDTH_BITS / BYTE_SIZE;
  localparam int LANE_WIDTH = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(LANES - 1);

  logic [LANE_WIDTH-1:0]      lane_r;
  logic [WORD_WIDTH_BITS-1:0] word_r;

  assign o_word       = word_r;
  assign o_word_ready = i_capture && (lane_r == LAST_LANE);

  // Lane counter and word register update.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      lane_r <= '0;
      word_r <= '0;
    end else if (i_clear) begin
      lane_r <= '0;
      word_r <= '0;
    end else if (i_capture) begin
      word_r[lane_r*BYTE_SIZE +: BYTE_SIZE] <= i_byte;
      if (lane_r == LAST_LANE) begin
        lane_r <= '0;
      end else begin
        lane_r <= lane_r + LANE_WIDTH'(1);
      end
    end else begin
      lane_r <= lane_r;
      word_r <= word_r;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Loads a program from the debug UART into instruction memory one
// word per write pulse; stops on HALT, a full memory or overflow.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int                         WORD_WIDTH_BITS = LOADER_WORD_WIDTH,
  parameter int                         BYTE_SIZE       = LOADER_BYTE_SIZE,
  parameter int                         MEM_SIZE_WORDS  = 10,
  parameter logic [WORD_WIDTH_BITS-1:0] HALT_INSTR      = LOADER_HALT_INSTR,
  parameter int                         COUNT_WIDTH     = $clog2(MEM_SIZE_WORDS + 1)
)(
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  instruction_loader_if.master    bus,
  output logic [COUNT_WIDTH-1:0]  o_word_count,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_overflow
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(MEM_SIZE_WORDS);

  state_e                     state_r;
  logic [COUNT_WIDTH-1:0]     count_r;
  logic [COUNT_WIDTH-1:0]     count_inc_s;
  logic                       write_done_s;
  logic                       capture_s;
  logic                       word_ready_s;
  logic [WORD_WIDTH_BITS-1:0] word_s;

  instruction_loader_byte_assembler #(
    .WORD_WIDTH_BITS (WORD_WIDTH_BITS),
    .BYTE_SIZE       (BYTE_SIZE)
  ) u_byte_assembler (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (state_r == ST_CLEAR),
    .i_capture    (capture_s),
    .i_byte       (bus.i_rx_data),
    .o_word       (word_s),
    .o_word_ready (word_ready_s)
  );

  // Byte acceptance and end-of-load decision; a byte landing in WRITE
  // is kept only when the load continues.
  always_comb begin
    capture_s = 1'b0;
    if (count_r == COUNT_MAX) begin
      count_inc_s = count_r;
    end else begin
      count_inc_s = count_r + COUNT_WIDTH'(1);
    end
    write_done_s = (word_s == HALT_INSTR) || (count_inc_s == COUNT_MAX);
    case (state_r)
      ST_RECV:  capture_s = bus.i_rx_valid && !i_start && !bus.i_mem_full;
      ST_WRITE: capture_s = bus.i_rx_valid && !i_start && !write_done_s;
      default:  capture_s = 1'b0;
    endcase
  end

  // Load sequencer and word counter.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r <= ST_IDLE;
      count_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= i_start ? ST_CLEAR : ST_IDLE;
        end
        ST_CLEAR: begin
          state_r <= ST_RECV;
          count_r <= '0;
        end
        ST_RECV: begin
          if (i_start) begin
            state_r <= ST_CLEAR;
          end else if (bus.i_rx_valid && bus.i_mem_full) begin
            state_r <= ST_ERROR;
          end else if (word_ready_s) begin
            state_r <= ST_WRITE;
          end else begin
            state_r <= ST_RECV;
          end
        end
        ST_WRITE: begin
          count_r <= count_inc_s;
          if (i_start) begin
            state_r <= ST_CLEAR;
          end else if (write_done_s) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RECV;
          end
        end
        ST_DONE: begin
          state_r <= i_start ? ST_CLEAR : ST_DONE;
        end
        ST_ERROR: begin
          state_r <= i_start ? ST_CLEAR : ST_ERROR;
        end
        default: begin
          state_r <= ST_IDLE;
          count_r <= '0;
        end
      endcase
    end
  end

  assign bus.o_clear       = (state_r == ST_CLEAR);
  assign bus.o_inst_write  = (state_r == ST_WRITE);
  assign bus.o_instruction = word_s;
  assign o_word_count      = count_r;
  assign o_busy            = is_busy(state_r);
  assign o_done            = (state_r == ST_DONE);
  assign o_overflow        = (state_r == ST_ERROR);

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: writes and clear pulses are
// logged on the falling edge and compared against hand-computed values.
module tb_instruction_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] word_count;
  logic       busy;
  logic       done;
  logic       overflow;

  int          checks = 0;
  int          failures = 0;
  int          clear_cnt = 0;
  int          clear_base;
  logic [31:0] wr_q[$];
  logic [31:0] w;

  instruction_loader_if #(.WORD_WIDTH_BITS(32), .BYTE_SIZE(8)) bus ();

  instruction_loader #(.MEM_SIZE_WORDS(10)) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_start      (start),
    .bus          (bus),
    .o_word_count (word_count),
    .o_busy       (busy),
    .o_done       (done),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.o_inst_write === 1'b1) wr_q.push_back(bus.o_instruction);
    if (bus.o_clear === 1'b1) clear_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wr_at(input int idx);
    return (wr_q.size() > idx) ? wr_q[idx] : 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    tick();
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    strobe(b);
    tick();
  endtask

  task automatic send_word(input logic [31:0] wd);
    for (int i = 0; i < 4; i++) send_byte(wd[8*i +: 8]);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_rx_data  = 8'h00;
    bus.i_rx_valid = 1'b0;
    bus.i_mem_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_clear", 32'(bus.o_clear), 32'd0);
    check_val("rst_write", 32'(bus.o_inst_write), 32'd0);
    check_val("rst_instr", bus.o_instruction, 32'd0);
    check_val("rst_count", 32'(word_count), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick();

    // Bytes in IDLE are ignored
    send_word(32'h1234_5678);
    check_val("idle_nowrite", wr_q.size(), 32'd0);
    check_val("idle_busy", 32'(busy), 32'd0);

    // First word
    clear_base = clear_cnt;
    do_start();
    check_val("t1_clear", clear_cnt - clear_base, 32'd1);
    check_val("t1_busy_recv", 32'(busy), 32'd1);
    send_word(32'h8C01_0020);
    check_val("t1_nwr", wr_q.size(), 32'd1);
    check_val("t1_word", wr_at(0), 32'h8C01_0020);
    check_val("t1_count", 32'(word_count), 32'd1);
    check_val("t1_busy", 32'(busy), 32'd1);
    check_val("t1_done", 32'(done), 32'd0);

    // HALT terminates the load and is itself written
    wr_q.delete();
    do_start();
    check_val("t2_count0", 32'(word_count), 32'd0);
    send_word(32'h1122_3344);
    send_word(32'hA5A5_A5A5);
    send_word(32'h0000_0013);
    send_word(32'hFFFF_FFFF);
    check_val("t2_nwr", wr_q.size(), 32'd4);
    check_val("t2_w0", wr_at(0), 32'h1122_3344);
    check_val("t2_w2", wr_at(2), 32'h0000_0013);
    check_val("t2_halt", wr_at(3), 32'hFFFF_FFFF);
    check_val("t2_done", 32'(done), 32'd1);
    check_val("t2_busy", 32'(busy), 32'd0);
    check_val("t2_count", 32'(word_count), 32'd4);
    send_word(32'hCAFE_F00D);
    check_val("t2_ignored", wr_q.size(), 32'd4);
    check_val("t2_done_held", 32'(done), 32'd1);

    // Memory capacity terminates the load
    wr_q.delete();
    do_start();
    check_val("t3_done_clr", 32'(done), 32'd0);
    for (int i = 0; i < 9; i++) begin
      w = 32'h0101_0101 * (i + 1);
      send_word(w);
    end
    check_val("t3_done9", 32'(done), 32'd0);
    check_val("t3_count9", 32'(word_count), 32'd9);
    send_word(32'h0A0A_0A0A);
    check_val("t3_nwr", wr_q.size(), 32'd10);
    check_val("t3_w9", wr_at(9), 32'h0A0A_0A0A);
    check_val("t3_done", 32'(done), 32'd1);
    check_val("t3_count", 32'(word_count), 32'd10);
    send_word(32'h0B0B_0B0B);
    check_val("t3_ignored", wr_q.size(), 32'd10);
    check_val("t3_count_sat", 32'(word_count), 32'd10);

    // Byte with memory full -> overflow
    wr_q.delete();
    do_start();
    bus.i_mem_full = 1'b1;
    send_byte(8'h55);
    check_val("t4_nowrite", wr_q.size(), 32'd0);
    check_val("t4_ovf", 32'(overflow), 32'd1);
    check_val("t4_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    send_byte(8'h66);
    check_val("t4_ovf_held", 32'(overflow), 32'd1);
    bus.i_mem_full = 1'b0;
    clear_base = clear_cnt;
    do_start();
    check_val("t4_clear", clear_cnt - clear_base, 32'd1);
    check_val("t4_ovf_clr", 32'(overflow), 32'd0);
    check_val("t4_busy_again", 32'(busy), 32'd1);

    // Byte arriving during WRITE becomes lane 0 of the next word
    wr_q.delete();
    strobe(8'hA1);
    strobe(8'hA2);
    strobe(8'hA3);
    strobe(8'hA4);
    strobe(8'h5B);
    send_byte(8'h6C);
    send_byte(8'h7D);
    send_byte(8'h8E);
    check_val("t5_nwr", wr_q.size(), 32'd2);
    check_val("t5_w0", wr_at(0), 32'hA4A3_A2A1);
    check_val("t5_w1", wr_at(1), 32'h8E7D_6C5B);
    check_val("t5_count", 32'(word_count), 32'd2);

    // Restart mid-word; start beats a simultaneous byte
    wr_q.delete();
    clear_base = clear_cnt;
    do_start();
    send_byte(8'h11);
    send_byte(8'h22);
    bus.i_rx_data  = 8'hEE;
    bus.i_rx_valid = 1'b1;
    start          = 1'b1;
    tick();
    bus.i_rx_valid = 1'b0;
    start          = 1'b0;
    tick();
    send_word(32'h0403_0201);
    check_val("t6_clear", clear_cnt - clear_base, 32'd2);
    check_val("t6_nwr", wr_q.size(), 32'd1);
    check_val("t6_word", wr_at(0), 32'h0403_0201);
    check_val("t6_count", 32'(word_count), 32'd1);

    // Asynchronous reset mid-word
    send_byte(8'hAB);
    send_byte(8'hCD);
    check_val("t7_busy_pre", 32'(busy), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("t7_busy", 32'(busy), 32'd0);
    check_val("t7_count", 32'(word_count), 32'd0);
    check_val("t7_instr", bus.o_instruction, 32'd0);
    check_val("t7_write", 32'(bus.o_inst_write), 32'd0);
    check_val("t7_clear", 32'(bus.o_clear), 32'd0);
    check_val("t7_done", 32'(done), 32'd0);
    check_val("t7_ovf", 32'(overflow), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    wr_q.delete();
    send_word(32'hDEAD_0001);
    check_val("t7_idle_nowrite", wr_q.size(), 32'd0);
    do_start();
    send_word(32'h0000_0093);
    check_val("t7_reload", wr_at(0), 32'h0000_0093);
    check_val("t7_reload_cnt", 32'(word_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
